// File: rtl/fpu_pkg.sv
// fpu_pkg: shared class/state encodings, RV32F opcode fields and default latencies for the FPU sequencer.
package fpu_pkg;

    typedef enum logic [1:0] {
        CLS_MISC = 2'd0,
        CLS_ADD  = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_ITER = 2'd3
    } op_class_e;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_PIPE = 3'd2;
    localparam logic [2:0] ST_WAIT_ITER = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam logic [6:0] OPC_OP_FP = 7'b1010011;
    localparam logic [1:0] OPC_FMA_HI = 2'b10;

    localparam logic [4:0] F5_FADD  = 5'b00000;
    localparam logic [4:0] F5_FSUB  = 5'b00001;
    localparam logic [4:0] F5_FMUL  = 5'b00010;
    localparam logic [4:0] F5_FDIV  = 5'b00011;
    localparam logic [4:0] F5_FSQRT = 5'b01011;

    localparam logic [2:0] FMA_MADD  = 3'b000;
    localparam logic [2:0] FMA_MSUB  = 3'b001;
    localparam logic [2:0] FMA_NMSUB = 3'b010;
    localparam logic [2:0] FMA_NMADD = 3'b011;

    localparam int DEF_ADD_LAT = 3;
    localparam int DEF_MUL_LAT = 4;
    localparam int DEF_FMA_LAT = 5;

    function automatic logic [2:0] lat_m1(input int lat);
        return 3'(lat - 1);
    endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// fpu_sequencer_if: core/unit-facing signals of the FPU sequencer; slave is the sequencer side.
interface fpu_sequencer_if;
    logic        fpuEnable_i;
    logic [31:0] instr_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [31:0] rs3_i;
    logic        kill_i;
    logic [31:0] unitResult_i;
    logic        iterDone_i;
    logic        busy_o;
    logic        start_o;
    logic [1:0]  unitSel_o;
    logic [31:0] opA_o;
    logic [31:0] opB_o;
    logic [31:0] opC_o;
    logic [31:0] instrQ_o;
    logic        done_o;
    logic [31:0] fpuOut_o;

    modport slave (
        input  fpuEnable_i, instr_i, rs1_i, rs2_i, rs3_i, kill_i, unitResult_i, iterDone_i,
        output busy_o, start_o, unitSel_o, opA_o, opB_o, opC_o, instrQ_o, done_o, fpuOut_o
    );

    modport master (
        output fpuEnable_i, instr_i, rs1_i, rs2_i, rs3_i, kill_i, unitResult_i, iterDone_i,
        input  busy_o, start_o, unitSel_o, opA_o, opB_o, opC_o, instrQ_o, done_o, fpuOut_o
    );
endinterface

// File: rtl/fpu_op_class.sv
// fpu_op_class: decodes an RV32F instruction word into its latency class and (latency - 1).
module fpu_op_class
    import fpu_pkg::*;
#(
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int FMA_LAT = DEF_FMA_LAT
) (
    input  logic [31:0] instr_i,
    output op_class_e   class_o,
    output logic [2:0]  lat_m1_o
);

    if (ADD_LAT < 1 || ADD_LAT > 8 || MUL_LAT < 1 || MUL_LAT > 8 || FMA_LAT < 1 || FMA_LAT > 8) begin : g_bad_lat
        $error("fpu_op_class: latencies must lie in 1..8 to fit the 3-bit counter");
    end

    logic [4:0] f5;
    logic       is_opfp;
    logic       is_fma;
    logic       unused_fields;

    assign unused_fields = ^instr_i[26:7];

    always_comb begin
        f5      = instr_i[31:27];
        is_opfp = instr_i[6:0] == OPC_OP_FP;
        is_fma  = instr_i[6:5] == OPC_FMA_HI && instr_i[1:0] == 2'b11 &&
                  instr_i[4:2] inside {FMA_MADD, FMA_MSUB, FMA_NMSUB, FMA_NMADD};
        class_o = CLS_MISC;
        if (is_fma || (is_opfp && f5 == F5_FMUL))
            class_o = CLS_MUL;
        else if (is_opfp && (f5 == F5_FADD || f5 == F5_FSUB))
            class_o = CLS_ADD;
        else if (is_opfp && (f5 == F5_FDIV || f5 == F5_FSQRT))
            class_o = CLS_ITER;
        lat_m1_o = is_fma ? lat_m1(FMA_LAT) : class_o == CLS_ADD ? lat_m1(ADD_LAT) : lat_m1(MUL_LAT);
    end

endmodule

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: issues one FP op at a time to the matching unit, waits out its latency
// or iterative done, and returns the result with a one-cycle done pulse.
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int FMA_LAT = DEF_FMA_LAT
) (
    input logic           clk_i,
    input logic           reset_i,
    fpu_sequencer_if.slave bus
);

    logic [2:0]  state_q, state_d, cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
    logic [31:0] instr_q, instr_d, out_q, out_d;
    logic [31:0] dec_instr;
    op_class_e   cls;
    logic [2:0]  lat;

    // Decode the live request while idle, the latched one once accepted.
    assign dec_instr = state_q == ST_IDLE ? bus.instr_i : instr_q;

    fpu_op_class #(
        .ADD_LAT(ADD_LAT),
        .MUL_LAT(MUL_LAT),
        .FMA_LAT(FMA_LAT)
    ) u_op_class (
        .instr_i (dec_instr),
        .class_o (cls),
        .lat_m1_o(lat)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        op_c_d  = op_c_q;
        instr_d = instr_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: if (bus.fpuEnable_i && !bus.kill_i) begin
                state_d = ST_ISSUE;
                sel_d   = cls;
                op_a_d  = bus.rs1_i;
                op_b_d  = bus.rs2_i;
                op_c_d  = bus.rs3_i;
                instr_d = bus.instr_i;
            end
            ST_ISSUE: begin
                state_d = cls == CLS_MISC ? ST_DONE : cls == CLS_ITER ? ST_WAIT_ITER : ST_WAIT_PIPE;
                cnt_d   = lat;
                out_d   = cls == CLS_MISC ? bus.unitResult_i : out_q;
            end
            ST_WAIT_PIPE: begin
                cnt_d   = cnt_q == 3'd0 ? cnt_q : cnt_q - 3'd1;
                state_d = cnt_q == 3'd0 ? ST_DONE : ST_WAIT_PIPE;
                out_d   = cnt_q == 3'd0 ? bus.unitResult_i : out_q;
            end
            ST_WAIT_ITER: if (bus.iterDone_i) begin
                state_d = ST_DONE;
                out_d   = bus.unitResult_i;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.kill_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            out_d   = out_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            op_c_q  <= '0;
            instr_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            op_c_q  <= op_c_d;
            instr_q <= instr_d;
            out_q   <= out_d;
        end
    end

    assign bus.busy_o    = (state_q == ST_IDLE && bus.fpuEnable_i) ||
                           state_q inside {ST_ISSUE, ST_WAIT_PIPE, ST_WAIT_ITER};
    assign bus.start_o   = state_q == ST_ISSUE;
    assign bus.done_o    = state_q == ST_DONE && !bus.kill_i;
    assign bus.unitSel_o = sel_q;
    assign bus.opA_o     = op_a_q;
    assign bus.opB_o     = op_b_q;
    assign bus.opC_o     = op_c_q;
    assign bus.instrQ_o  = instr_q;
    assign bus.fpuOut_o  = out_q;

endmodule
